pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit, five-stage pipeline (IF/ID/EX/MEM/WB). It combines three conditions into per-stage stall, bubble and flush controls: load-use hazards between EX and ID, taken branches resolved in EX, and multi-cycle data-memory waits in MEM. It also implements the processor's terminal HALT and memory-timeout ERROR states. It sits beside the pipeline registers and drives their enables directly.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_if.sv | 53 +++++
 rtl/pipeline_ctrl_load_use_detect.sv | 31 +++
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding, default widths and the register-field positions inside an
// instruction word.
package pipe_ctrl_pkg;

   localparam int REG_BITS_DEF = 3;
   localparam int INSTR_W_DEF  = 16;

   // Source register fields in the decode-stage instruction
   localparam int RS_LSB = 8;   // Rs = instr[10:8]
   localparam int RT_LSB = 5;   // Rt = instr[7:5]

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_HALT    = 2'd2,
      ST_ERROR   = 2'd3
   } pipe_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the stall/flush
// sequencer (slave). The performance counter signals exist only when
// PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
   parameter int REG_BITS = 3,
   parameter int INSTR_W  = 16,
   parameter int CNT_W    = 16
);
   logic [INSTR_W-1:0]  instr_ID;
   logic                memReadEnable_EX;
   logic                memWriteEnable_EX;
   logic [REG_BITS-1:0] regWriteNum_EX;
   logic                branchTaken_EX;
   logic                memReq_MEM;
   logic                memReady;
   logic                halt_WB;

   logic                stall_IF;
   logic                stall_ID;
   logic                bubble_EX;
   logic                stall_EX;
   logic                stall_MEM;
   logic                flush_IF;
   logic                flush_ID;
   logic                halted;
   logic                memErr;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0]    stallCycles;
   logic [CNT_W-1:0]    flushCount;
   logic [CNT_W-1:0]    loadUseCount;
`endif

   modport master (
      output instr_ID, memReadEnable_EX, memWriteEnable_EX, regWriteNum_EX,
             branchTaken_EX, memReq_MEM, memReady, halt_WB,
      input  stall_IF, stall_ID, bubble_EX, stall_EX, stall_MEM,
             flush_IF, flush_ID, halted, memErr
`ifdef PIPE_CTRL_PERF_EN
      , input stallCycles, flushCount, loadUseCount
`endif
   );

   modport slave (
      input  instr_ID, memReadEnable_EX, memWriteEnable_EX, regWriteNum_EX,
             branchTaken_EX, memReq_MEM, memReady, halt_WB,
      output stall_IF, stall_ID, bubble_EX, stall_EX, stall_MEM,
             flush_IF, flush_ID, halted, memErr
`ifdef PIPE_CTRL_PERF_EN
      , output stallCycles, flushCount, loadUseCount
`endif
   );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: flags when the instruction in EX is a load whose
// destination matches either source register of the instruction in ID.
// A store (read and write both set) is not a load.
module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_BITS = REG_BITS_DEF,
   parameter int INSTR_W  = INSTR_W_DEF
) (
   input  logic [INSTR_W-1:0]  i_instr_ID,
   input  logic                i_mem_read_ex,
   input  logic                i_mem_write_ex,
   input  logic [REG_BITS-1:0] i_reg_write_num_ex,
   output logic                o_load_use
);

   logic [REG_BITS-1:0] w_rs;
   logic [REG_BITS-1:0] w_rt;
   logic                w_unused_instr_bits;

   assign w_rs = i_instr_ID[RS_LSB +: REG_BITS];
   assign w_rt = i_instr_ID[RT_LSB +: REG_BITS];

   // Opcode and immediate bits play no part in hazard detection
   assign w_unused_instr_bits = ^{i_instr_ID[INSTR_W-1:RS_LSB+REG_BITS],
                                  i_instr_ID[RT_LSB-1:0]};

   assign o_load_use = i_mem_read_ex & ~i_mem_write_ex &
                       ((w_rs == i_reg_write_num_ex) | (w_rt == i_reg_write_num_ex));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Combines memory waits, taken branches and load-use hazards into per-stage
// stall/bubble/flush controls and owns the terminal HALT and ERROR states.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating event counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_BITS    = REG_BITS_DEF,
   parameter int INSTR_W     = INSTR_W_DEF,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   pipeline_ctrl_if.slave   bus
);

   localparam logic [1:0] S_RUN     = ST_RUN;
   localparam logic [1:0] S_MEMWAIT = ST_MEMWAIT;
   localparam logic [1:0] S_HALT    = ST_HALT;
   localparam logic [1:0] S_ERROR   = ST_ERROR;

   localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_next;
   logic              r_halted;
   logic              r_mem_err;

   logic w_load_use;
   logic w_mem_stall;
   logic w_hold;
   logic w_active;
   logic w_flush;
   logic w_bubble;

   load_use_detect #(
      .REG_BITS (REG_BITS),
      .INSTR_W  (INSTR_W)
   ) u_load_use_detect (
      .i_instr_ID         (bus.instr_ID),
      .i_mem_read_ex      (bus.memReadEnable_EX),
      .i_mem_write_ex     (bus.memWriteEnable_EX),
      .i_reg_write_num_ex (bus.regWriteNum_EX),
      .o_load_use         (w_load_use)
   );

   // Per-stage controls: freeze everything on a memory wait or in a terminal
   // state; otherwise a branch squashes, else a load-use hazard bubbles.
   always_comb begin
      w_mem_stall = bus.memReq_MEM & ~bus.memReady;
      w_hold      = ((r_state == S_RUN)     &  w_mem_stall)   |
                    ((r_state == S_MEMWAIT) & ~bus.memReady)  |
                     (r_state == S_HALT) | (r_state == S_ERROR);
      // A branch held in a frozen EX is acted on here, in the first
      // unfrozen cycle, and only once.
      w_active    = ((r_state == S_RUN)     & ~w_mem_stall)   |
                    ((r_state == S_MEMWAIT) &  bus.memReady);
      w_flush     = w_active & bus.branchTaken_EX;
      w_bubble    = w_active & ~bus.branchTaken_EX & w_load_use;
   end

   assign bus.stall_IF  = w_hold | w_bubble;
   assign bus.stall_ID  = w_hold | w_bubble;
   assign bus.stall_EX  = w_hold;
   assign bus.stall_MEM = w_hold;
   assign bus.bubble_EX = w_bubble;
   assign bus.flush_IF  = w_flush;
   assign bus.flush_ID  = w_flush;
   assign bus.halted    = r_halted;
   assign bus.memErr    = r_mem_err;

   // Next-state and wait-counter logic
   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      case (r_state)
         S_RUN: begin
            if (w_mem_stall) begin
               w_state_next    = S_MEMWAIT;
               w_wait_cnt_next = WAIT_W'(1);
            end else if (bus.halt_WB) begin
               w_state_next    = S_HALT;
            end
         end
         S_MEMWAIT: begin
            if (bus.memReady) begin
               w_state_next    = bus.halt_WB ? S_HALT : S_RUN;
               w_wait_cnt_next = '0;
            end else if (r_wait_cnt == WAIT_MAX) begin
               w_state_next    = S_ERROR;
            end else begin
               w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            w_state_next = r_state;
         end
      endcase
   end

   // State, wait counter and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_halted   <= (w_state_next == S_HALT);
         r_mem_err  <= (w_state_next == S_ERROR);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Event order: 0 = stall_IF cycles, 1 = flush cycles, 2 = load-use bubbles
   logic [2:0] w_perf_evt;
   assign w_perf_evt = {w_bubble, w_flush, w_hold | w_bubble};

   for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_W-1:0] r_cnt;
      // Saturating event counter
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_perf_evt[gi] && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.stallCycles  = g_perf[0].r_cnt;
   assign bus.flushCount   = g_perf[1].r_cnt;
   assign bus.loadUseCount = g_perf[2].r_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (MEM_TIMEOUT = 4).
module tb_pipeline_ctrl;
   import pipe_ctrl_pkg::*;

   // Output vector order: {stall_IF, stall_ID, stall_EX, stall_MEM,
   //                       bubble_EX, flush_IF, flush_ID, halted, memErr}
   localparam logic [8:0] C_NONE = 9'b0000_0000_0;
   localparam logic [8:0] C_LU   = 9'b1100_1000_0;
   localparam logic [8:0] C_FL   = 9'b0000_0110_0;
   localparam logic [8:0] C_ST   = 9'b1111_0000_0;
   localparam logic [8:0] C_HLT  = 9'b1111_0001_0;
   localparam logic [8:0] C_ERR  = 9'b1111_0000_1;

   logic clk;
   logic rst_n;
   int   vectors_applied;
   int   miscompares;

   pipeline_ctrl_if #(.REG_BITS(3), .INSTR_W(16), .CNT_W(16)) pif ();

   pipeline_ctrl #(
      .REG_BITS    (3),
      .INSTR_W     (16),
      .MEM_TIMEOUT (4),
      .CNT_W       (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (pif)
   );

   logic [8:0] obs;
   assign obs = {pif.stall_IF, pif.stall_ID, pif.stall_EX, pif.stall_MEM,
                 pif.bubble_EX, pif.flush_IF, pif.flush_ID, pif.halted, pif.memErr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      pif.instr_ID          = 16'h0000;
      pif.memReadEnable_EX  = 1'b0;
      pif.memWriteEnable_EX = 1'b0;
      pif.regWriteNum_EX    = 3'd7;
      pif.branchTaken_EX    = 1'b0;
      pif.memReq_MEM        = 1'b0;
      pif.memReady          = 1'b0;
      pif.halt_WB           = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #3;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected %b", obs, C_NONE);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL reset_release: got %b expected %b", obs, C_NONE);
      end
      $display("test_reset: outputs %b", obs);
   endtask

   task automatic test_load_use();
      // {instr, regWriteNum, memRead, expected}
      logic [15:0] instr_tab [5] = '{16'h0200, 16'h0200, 16'h01A0, 16'h01A0, 16'h0200};
      logic [2:0]  rw_tab    [5] = '{3'd2,     3'd2,     3'd5,     3'd3,     3'd2};
      logic        rd_tab    [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
      logic [8:0]  exp_tab   [5] = '{C_LU,     C_NONE,   C_LU,     C_NONE,   C_NONE};
      for (int k = 0; k < 5; k++) begin
         idle();
         pif.instr_ID         = instr_tab[k];
         pif.regWriteNum_EX   = rw_tab[k];
         pif.memReadEnable_EX = rd_tab[k];
         #1;
         vectors_applied++;
         if (obs !== exp_tab[k]) begin
            miscompares++;
            $display("FAIL load_use[%0d]: got %b expected %b", k, obs, exp_tab[k]);
         end
         $display("test_load_use[%0d]: instr=%h rw=%0d rd=%b -> %b", k,
                  instr_tab[k], rw_tab[k], rd_tab[k], obs);
         cyc();
      end
   endtask

   task automatic test_branch_load_use();
      idle();
      pif.instr_ID         = 16'h0200;
      pif.regWriteNum_EX   = 3'd2;
      pif.memReadEnable_EX = 1'b1;
      pif.branchTaken_EX   = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_FL) begin
         miscompares++;
         $display("FAIL branch_with_load_use: got %b expected %b", obs, C_FL);
      end
      $display("test_branch_load_use: %b", obs);
      cyc();
      idle();
      pif.branchTaken_EX = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_FL) begin
         miscompares++;
         $display("FAIL branch_only: got %b expected %b", obs, C_FL);
      end
      $display("test_branch_only: %b", obs);
      cyc();
   endtask

   task automatic test_store_not_load();
      idle();
      pif.instr_ID          = 16'h01A0;   // Rt = R5
      pif.regWriteNum_EX    = 3'd5;
      pif.memReadEnable_EX  = 1'b1;
      pif.memWriteEnable_EX = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL store_not_load: got %b expected %b", obs, C_NONE);
      end
      $display("test_store_not_load: %b", obs);
      cyc();
   endtask

   task automatic test_mem_wait();
      idle();
      pif.memReq_MEM = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors_applied++;
         if (obs !== C_ST) begin
            miscompares++;
            $display("FAIL mem_wait_cycle%0d: got %b expected %b", k, obs, C_ST);
         end
         $display("test_mem_wait: wait cycle %0d -> %b", k, obs);
         cyc();
      end
      pif.memReady = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL mem_wait_release: got %b expected %b", obs, C_NONE);
      end
      $display("test_mem_wait: ready cycle -> %b", obs);
      cyc();
      // Back in RUN: memReady low without a request must not stall
      idle();
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL mem_wait_back_to_run: got %b expected %b", obs, C_NONE);
      end
      cyc();
      // Ready in the first request cycle: no stall, no state change
      pif.memReq_MEM = 1'b1;
      pif.memReady   = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL mem_ready_first_cycle: got %b expected %b", obs, C_NONE);
      end
      cyc();
      idle();
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL mem_ready_first_no_wait: got %b expected %b", obs, C_NONE);
      end
      $display("test_mem_wait: first-cycle ready -> %b", obs);
      cyc();
   endtask

   task automatic test_branch_during_wait();
      idle();
      pif.memReq_MEM     = 1'b1;
      pif.branchTaken_EX = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         vectors_applied++;
         if (obs !== C_ST) begin
            miscompares++;
            $display("FAIL frozen_branch%0d: got %b expected %b", k, obs, C_ST);
         end
         cyc();
      end
      pif.memReady = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_FL) begin
         miscompares++;
         $display("FAIL branch_after_wait: got %b expected %b", obs, C_FL);
      end
      $display("test_branch_during_wait: release cycle -> %b", obs);
      cyc();
      idle();
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL branch_not_repeated: got %b expected %b", obs, C_NONE);
      end
      cyc();
   endtask

   task automatic test_reset_mid_wait();
      idle();
      pif.memReq_MEM = 1'b1;
      cyc();
      cyc();
      pif.memReq_MEM = 1'b0;   // in MEMWAIT, stalls still asserted
      #1;
      vectors_applied++;
      if (obs !== C_ST) begin
         miscompares++;
         $display("FAIL mid_wait_stall: got %b expected %b", obs, C_ST);
      end
      rst_n = 1'b0;
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL async_reset_mid_wait: got %b expected %b", obs, C_NONE);
      end
      $display("test_reset_mid_wait: %b", obs);
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_timeout();
      idle();
      pif.memReq_MEM = 1'b1;
      // RUN request cycle + 4 MEMWAIT cycles, then ERROR
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors_applied++;
         if (obs !== C_ST) begin
            miscompares++;
            $display("FAIL timeout_wait%0d: got %b expected %b", k, obs, C_ST);
         end
         cyc();
      end
      #1;
      vectors_applied++;
      if (obs !== C_ERR) begin
         miscompares++;
         $display("FAIL timeout_error: got %b expected %b", obs, C_ERR);
      end
      $display("test_timeout: error state -> %b", obs);
      pif.memReady = 1'b1;
      cyc();
      #1;
      vectors_applied++;
      if (obs !== C_ERR) begin
         miscompares++;
         $display("FAIL error_sticky: got %b expected %b", obs, C_ERR);
      end
      idle();
      rst_n = 1'b0;
      #1;
      vectors_applied++;
      if (obs !== C_NONE) begin
         miscompares++;
         $display("FAIL error_reset: got %b expected %b", obs, C_NONE);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_halt();
      idle();
      pif.halt_WB        = 1'b1;
      pif.branchTaken_EX = 1'b1;
      #1;
      vectors_applied++;
      if (obs !== C_FL) begin
         miscompares++;
         $display("FAIL halt_same_cycle: got %b expected %b", obs, C_FL);
      end
      cyc();
      for (int k = 0; k < 10; k++) begin
         pif.instr_ID          = 16'($urandom);
         pif.memReadEnable_EX  = 1'($urandom);
         pif.memWriteEnable_EX = 1'($urandom);
         pif.regWriteNum_EX    = 3'($urandom);
         pif.branchTaken_EX    = 1'($urandom);
         pif.memReq_MEM        = 1'($urandom);
         pif.memReady          = 1'($urandom);
         pif.halt_WB           = 1'($urandom);
         #1;
         vectors_applied++;
         if (obs !== C_HLT) begin
            miscompares++;
            $display("FAIL halt_hold%0d: got %b expected %b", k, obs, C_HLT);
         end
         $display("test_halt: cycle %0d -> %b", k, obs);
         cyc();
      end
      do_reset();
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      do_reset();
      // one load-use bubble
      pif.instr_ID         = 16'h0200;
      pif.regWriteNum_EX   = 3'd2;
      pif.memReadEnable_EX = 1'b1;
      cyc();
      // one flush
      idle();
      pif.branchTaken_EX = 1'b1;
      cyc();
      // one memory stall cycle, then ready
      idle();
      pif.memReq_MEM = 1'b1;
      cyc();
      pif.memReady = 1'b1;
      cyc();
      idle();
      #1;
      vectors_applied++;
      if (pif.stallCycles !== 16'd2) begin
         miscompares++;
         $display("FAIL perf_stallCycles: got %0d expected 2", pif.stallCycles);
      end
      vectors_applied++;
      if (pif.flushCount !== 16'd1) begin
         miscompares++;
         $display("FAIL perf_flushCount: got %0d expected 1", pif.flushCount);
      end
      vectors_applied++;
      if (pif.loadUseCount !== 16'd1) begin
         miscompares++;
         $display("FAIL perf_loadUseCount: got %0d expected 1", pif.loadUseCount);
      end
      $display("test_perf: stall=%0d flush=%0d loaduse=%0d",
               pif.stallCycles, pif.flushCount, pif.loadUseCount);
   endtask
`endif

   initial begin
      vectors_applied = 0;
      miscompares     = 0;
      rst_n           = 1'b1;
      idle();
      #2;
      test_reset();
      test_load_use();
      test_branch_load_use();
      test_store_not_load();
      test_mem_wait();
      test_branch_during_wait();
      test_reset_mid_wait();
      test_timeout();
      test_halt();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
